// File: rtl/spi_bf_pkg.sv
// Shared definitions for the SPI byte-buffer slice: default geometry,
// the one-hot pointer type and a helper that decodes a pointer to a slot index.
package spi_bf_pkg;

  localparam int BF_SLOTS = 4;
  localparam int BF_W     = 8;

  typedef logic [BF_SLOTS-1:0] bf_ptr_t;

  localparam bf_ptr_t BF_PTR_RST = bf_ptr_t'(1);

  // Lowest set bit wins, so a corrupted multi-hot pointer still decodes deterministically
  function automatic logic [$clog2(BF_SLOTS)-1:0] onehot_idx(input bf_ptr_t p);
    logic [$clog2(BF_SLOTS)-1:0] idx;
    idx = '0;
    for (int i = BF_SLOTS - 1; i >= 0; i--) begin
      if (p[i]) idx = i[$clog2(BF_SLOTS)-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_bf_ptr_rot.sv
// One-hot pointer register: async reset to bit 0, synchronous clear back to
// bit 0, and a pure rotate-left on enable (never re-normalised).
module spi_bf_ptr_rot #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [N-1:0] o_ptr
);

  logic [N-1:0] r_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= N'(1);
    end else if (i_clr) begin
      r_ptr <= N'(1);
    end else if (i_en) begin
      r_ptr <= {r_ptr[N-2:0], r_ptr[N-1]};
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/spi_bf_slot_buffer.sv
// First-word-fall-through slot buffer between the SPI shift engine and the
// execute unit, with exported one-hot pointers and sticky over/underflow flags.
module spi_bf_slot_buffer
  import spi_bf_pkg::*;
#(
  parameter  int M  = BF_SLOTS,
  parameter  int W  = BF_W,
  localparam int CW = $clog2(M + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [W-1:0]  i_wr_data,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic [W-1:0]  o_rd_data,
  output logic [M-1:0]  o_wr_ptr,
  output logic [M-1:0]  o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_overflow,
  output logic          o_underflow,
  input  logic          i_err_clr
);

  logic [W-1:0]  r_slot [M];
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic [W-1:0]  w_rd_data;
  logic [M-1:0]  w_wr_ptr;
  logic [M-1:0]  w_rd_ptr;

  assign w_push = i_wr_valid & ~r_full;
  assign w_pop  = i_rd_ready & ~r_empty;

  spi_bf_ptr_rot #(.N(M)) u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_push),
    .i_clr (i_flush),
    .o_ptr (w_wr_ptr)
  );

  spi_bf_ptr_rot #(.N(M)) u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_pop),
    .i_clr (i_flush),
    .o_ptr (w_rd_ptr)
  );

  // Slots are written by one-hot decode rather than an index, so no reset is needed here
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < M; i++) begin
      if (w_push && !i_flush && w_wr_ptr[i]) r_slot[i] <= i_wr_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < M; i++) begin
      if (w_rd_ptr[i]) w_rd_data = w_rd_data | r_slot[i];
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Full/empty are registered from the next count so they never lag the count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(M));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Sticky flags: a fresh error in the same cycle as a clear keeps the flag set
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (i_wr_valid & r_full)  | (r_overflow  & ~i_err_clr);
      r_underflow <= (i_rd_ready & r_empty) | (r_underflow & ~i_err_clr);
    end
  end

  assign o_wr_ready  = ~r_full;
  assign o_rd_valid  = ~r_empty;
  assign o_rd_data   = w_rd_data;
  assign o_wr_ptr    = w_wr_ptr;
  assign o_rd_ptr    = w_rd_ptr;
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_spi_bf_slot_buffer.sv
// Self-checking bench for spi_bf_slot_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_spi_bf_slot_buffer;

  localparam int M  = 4;
  localparam int W  = 8;
  localparam int CW = $clog2(M + 1);

  logic          clk;
  logic          rst;
  logic          flush;
  logic          wrValid;
  logic          wrReady;
  logic [W-1:0]  wrData;
  logic          rdValid;
  logic          rdReady;
  logic [W-1:0]  rdData;
  logic [M-1:0]  wrPtr;
  logic [M-1:0]  rdPtr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic          errClr;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, pointers as plain slot numbers
  logic [W-1:0] modelQ[$];
  int           modelWrIdx;
  int           modelRdIdx;
  logic         modelOvf;
  logic         modelUnf;

  spi_bf_slot_buffer #(.M(M), .W(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_wr_valid  (wrValid),
    .o_wr_ready  (wrReady),
    .i_wr_data   (wrData),
    .o_rd_valid  (rdValid),
    .i_rd_ready  (rdReady),
    .o_rd_data   (rdData),
    .o_wr_ptr    (wrPtr),
    .o_rd_ptr    (rdPtr),
    .o_count     (count),
    .o_full      (full),
    .o_empty     (empty),
    .o_overflow  (overflow),
    .o_underflow (underflow),
    .i_err_clr   (errClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelWrIdx = 0;
    modelRdIdx = 0;
    modelOvf   = 1'b0;
    modelUnf   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelEdge(input logic wv, input logic [W-1:0] wd, input logic rr,
                           input logic fl, input logic clr);
    bit wasFull  = (modelQ.size() == M);
    bit wasEmpty = (modelQ.size() == 0);
    bit doPush   = wv && !wasFull;
    bit doPop    = rr && !wasEmpty;
    modelOvf = (wv && wasFull) || (modelOvf && !clr);
    modelUnf = (rr && wasEmpty) || (modelUnf && !clr);
    if (fl) begin
      modelQ.delete();
      modelWrIdx = 0;
      modelRdIdx = 0;
    end else begin
      if (doPop) begin
        void'(modelQ.pop_front());
        modelRdIdx = (modelRdIdx + 1) % M;
      end
      if (doPush) begin
        modelQ.push_back(wd);
        modelWrIdx = (modelWrIdx + 1) % M;
      end
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [W-1:0] wd, input logic rr,
                               input logic fl, input logic clr);
    wrValid = wv;
    wrData  = wd;
    rdReady = rr;
    flush   = fl;
    errClr  = clr;
    @(posedge clk);
    modelEdge(wv, wd, rr, fl, clr);
    #1;
    wrValid = 1'b0;
    rdReady = 1'b0;
    flush   = 1'b0;
    errClr  = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    int n = modelQ.size();
    check({tag, ".count"},     32'(count),     32'(n));
    check({tag, ".full"},      32'(full),      32'(n == M));
    check({tag, ".empty"},     32'(empty),     32'(n == 0));
    check({tag, ".wrReady"},   32'(wrReady),   32'(n != M));
    check({tag, ".rdValid"},   32'(rdValid),   32'(n != 0));
    check({tag, ".wrPtr"},     32'(wrPtr),     32'(1) << modelWrIdx);
    check({tag, ".rdPtr"},     32'(rdPtr),     32'(1) << modelRdIdx);
    check({tag, ".overflow"},  32'(overflow),  32'(modelOvf));
    check({tag, ".underflow"}, 32'(underflow), 32'(modelUnf));
    if (n != 0) check({tag, ".rdData"}, 32'(rdData), 32'(modelQ[0]));
  endtask

  initial begin
    logic [W-1:0] fillBytes [4];
    fillBytes[0] = 8'hA1;
    fillBytes[1] = 8'hB2;
    fillBytes[2] = 8'hC3;
    fillBytes[3] = 8'hD4;

    rst = 1'b1; flush = 1'b0; wrValid = 1'b0; wrData = '0;
    rdReady = 1'b0; errClr = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    check("reset.wrPtrConst", 32'(wrPtr), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // Fill with four bytes
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillBytes[i], 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d", i));
    end
    check("fill.fullConst", 32'(full), 32'h1);
    check("fill.wrPtrWrap", 32'(wrPtr), 32'h1);

    // Overflow while full, then hold, then clear
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checkOutput("ovfSet");
    check("ovf.headKept", 32'(rdData), 32'hA1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovfHold");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("ovfClr");
    check("ovf.clearedConst", 32'(overflow), 32'h0);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d.dataConst", i), 32'(rdData), 32'(fillBytes[i]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("drain%0d", i));
    end
    check("drain.rdPtrWrap", 32'(rdPtr), 32'h1);
    check("drain.emptyConst", 32'(empty), 32'h1);

    // Underflow on empty; pointers must not move
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("unfSet");
    check("unf.setConst", 32'(underflow), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("unfClr");

    // Push with a simultaneous clear that also overflows: set must win
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    checkOutput("setWins");
    check("setWins.const", 32'(overflow), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("toTwo");

    // Steady state at count 2 with simultaneous push and pop
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h55 + i), 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("pushPop%0d", i));
    end
    check("pushPop.countConst", 32'(count), 32'h2);

    // Flush at count 3 with a push in the same cycle
    applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    checkOutput("preFlush");
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
    checkOutput("flush");
    check("flush.countConst", 32'(count), 32'h0);
    check("flush.rdValid", 32'(rdValid), 32'h0);

    // Async reset mid-cycle at count 2
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    checkOutput("preRst");
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncRst");
    check("asyncRst.countConst", 32'(count), 32'h0);
    #1;
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic wv, rr, fl, clr;
      logic [W-1:0] wd;
      wv  = 1'($urandom_range(0, 99) < 60);
      rr  = 1'($urandom_range(0, 99) < 55);
      fl  = 1'($urandom_range(0, 99) < 3);
      clr = 1'($urandom_range(0, 99) < 8);
      wd  = 8'($urandom);
      applyStimulus(wv, wd, rr, fl, clr);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
